// File: rtl/ddr3_rx_align_pkg.sv
// Shared types and failure codes for the DDR3 RX lane alignment controller.
package ddr3_rx_align_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_STEP,
      ST_CENTER,
      ST_FIN_OK,
      ST_FIN_ERR
   } state_e;

   typedef enum logic {
      MODE_ALIGN,
      MODE_SWEEP
   } mode_e;

   // Sub-phases of centring: width check, decision/low gap, decrement pulse.
   typedef enum logic [1:0] {
      CP_ENTRY,
      CP_GAP,
      CP_MOVE
   } ctr_phase_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_NOALIGN = 2'd1;
   localparam logic [1:0] FC_NARROW  = 2'd2;
   localparam logic [1:0] FC_RANGE   = 2'd3;

endpackage

// File: rtl/ddr3_rx_pattern_chk.sv
// Consecutive-match checker: after start, compares the word each cycle until
// a mismatch or MATCH_CNT matches in a row; done/pass are valid in that cycle.
module ddr3_rx_pattern_chk #(
   parameter int DATA_W    = 8,
   parameter int MATCH_CNT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic [DATA_W-1:0] pattern_i,
   output logic              done_o,
   output logic              pass_o
);
   localparam int CNT_W = $clog2(MATCH_CNT + 1);

   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match;
   logic             last;

   assign match  = (rx_data_i == pattern_i);
   assign last   = (cnt_q == CNT_W'(MATCH_CNT - 1));
   assign done_o = active_q && (!match || last);
   assign pass_o = active_q && match && last;

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         active_d = 1'b1;
         cnt_d    = '0;
      end else if (active_q) begin
         if (done_o) active_d = 1'b0;
         else        cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ddr3_rx_lane_align.sv
// Read-side training for one DDR3 DQ lane: bit-slip to word alignment, sweep
// the delay line for the data-valid window, then park at the window centre.
//
// state      | meaning
// IDLE       | waiting for START
// LOAD       | delay line load pulse (tap 0)
// SETTLE     | wait SETTLE cycles after a slip/load/move
// CHECK      | compare MATCH_CNT consecutive words
// SLIP       | bit-slip pulse
// STEP       | increment the delay by one tap
// CENTER     | check window width, walk back down to the centre tap
// FIN_OK     | set DONE
// FIN_ERR    | set FAIL
module ddr3_rx_lane_align
   import ddr3_rx_align_pkg::*;
#(
   parameter int                DATA_W        = 8,
   parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hB4,
   parameter int                SETTLE        = 8,
   parameter int                MATCH_CNT     = 4,
   parameter int                TAP_W         = 8,
   parameter int                MAX_TAPS      = 128,
   parameter int                MIN_WIN       = 4
) (
   input  logic              fab_clk_i,
   input  logic              rx_sync_rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              delay_line_out_of_range_i,
   output logic              rx_bit_slip_o,
   output logic              delay_line_load_o,
   output logic              delay_line_move_o,
   output logic              delay_line_direction_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [1:0]        fail_code_o,
   output logic [TAP_W-1:0]  tap_cur_o,
   output logic [TAP_W-1:0]  win_start_o,
   output logic [TAP_W-1:0]  win_end_o,
   output logic [TAP_W-1:0]  tap_center_o
);
   localparam int               SLIP_W    = $clog2(DATA_W);
   localparam int               SET_W     = $clog2(SETTLE + 1);
   localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(DATA_W - 1);
   localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE - 1);
   localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(MAX_TAPS - 1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   ctr_phase_e        phase_q, phase_d;
   logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              oor_seen_q, oor_seen_d;
   logic              dir_q, dir_d;
   logic [TAP_W-1:0]  tap_cur_q, tap_cur_d;
   logic [TAP_W-1:0]  win_start_q, win_start_d;
   logic [TAP_W-1:0]  win_end_q, win_end_d;
   logic [TAP_W-1:0]  tap_center_q, tap_center_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic [1:0]        fail_code_q, fail_code_d;

   logic              chk_start, chk_done, chk_pass, check_ok;
   logic [TAP_W:0]    win_width, center_sum;

   ddr3_rx_pattern_chk #(
      .DATA_W    (DATA_W),
      .MATCH_CNT (MATCH_CNT)
   ) u_chk (
      .clk_i     (fab_clk_i),
      .rst_i     (rx_sync_rst_i),
      .start_i   (chk_start),
      .rx_data_i (rx_data_i),
      .pattern_i (TRAIN_PATTERN),
      .done_o    (chk_done),
      .pass_o    (chk_pass)
   );

   // An out-of-range flag during a sweep settle poisons the following check.
   assign check_ok   = chk_pass && !oor_seen_q;
   assign win_width  = {1'b0, win_end_q} - {1'b0, win_start_q} + (TAP_W+1)'(1);
   assign center_sum = {1'b0, win_start_q} + {1'b0, win_end_q};

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      phase_d      = phase_q;
      slip_cnt_d   = slip_cnt_q;
      settle_d     = settle_q;
      oor_seen_d   = oor_seen_q;
      dir_d        = dir_q;
      tap_cur_d    = tap_cur_q;
      win_start_d  = win_start_q;
      win_end_d    = win_end_q;
      tap_center_d = tap_center_q;
      busy_d       = busy_q;
      done_d       = done_q;
      fail_d       = fail_q;
      fail_code_d  = fail_code_q;
      chk_start    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               done_d       = 1'b0;
               fail_d       = 1'b0;
               fail_code_d  = FC_NONE;
               win_start_d  = '0;
               win_end_d    = '0;
               tap_center_d = '0;
               slip_cnt_d   = '0;
               tap_cur_d    = '0;
               busy_d       = 1'b1;
               dir_d        = 1'b1;
               mode_d       = MODE_ALIGN;
               state_d      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            settle_d   = SETTLE_LD;
            oor_seen_d = 1'b0;
            state_d    = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (mode_q == MODE_SWEEP && delay_line_out_of_range_i) oor_seen_d = 1'b1;
            if (settle_q == '0) begin
               chk_start = 1'b1;
               state_d   = ST_CHECK;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         ST_CHECK: begin
            if (chk_done) begin
               if (mode_q == MODE_ALIGN) begin
                  if (check_ok) begin
                     win_start_d = '0;
                     win_end_d   = '0;
                     mode_d      = MODE_SWEEP;
                     state_d     = ST_STEP;
                  end else if (slip_cnt_q == SLIP_LAST) begin
                     fail_code_d = FC_NOALIGN;
                     state_d     = ST_FIN_ERR;
                  end else begin
                     state_d = ST_SLIP;
                  end
               end else if (check_ok) begin
                  win_end_d = tap_cur_q;
                  state_d   = ST_STEP;
               end else begin
                  phase_d = CP_ENTRY;
                  state_d = ST_CENTER;
               end
            end
         end
         ST_SLIP: begin
            slip_cnt_d = slip_cnt_q + SLIP_W'(1);
            settle_d   = SETTLE_LD;
            oor_seen_d = 1'b0;
            state_d    = ST_SETTLE;
         end
         ST_STEP: begin
            if (tap_cur_q == TAP_LAST) begin
               phase_d = CP_ENTRY;
               state_d = ST_CENTER;
            end else begin
               tap_cur_d  = tap_cur_q + TAP_W'(1);
               settle_d   = SETTLE_LD;
               oor_seen_d = 1'b0;
               state_d    = ST_SETTLE;
            end
         end
         ST_CENTER: begin
            case (phase_q)
               CP_ENTRY: begin
                  if (win_width < (TAP_W+1)'(MIN_WIN)) begin
                     fail_code_d = FC_NARROW;
                     state_d     = ST_FIN_ERR;
                  end else if (delay_line_out_of_range_i) begin
                     fail_code_d = FC_RANGE;
                     state_d     = ST_FIN_ERR;
                  end else begin
                     tap_center_d = TAP_W'(center_sum >> 1);
                     dir_d        = 1'b0;
                     phase_d      = CP_GAP;
                  end
               end
               CP_GAP: begin
                  if (delay_line_out_of_range_i) begin
                     fail_code_d = FC_RANGE;
                     state_d     = ST_FIN_ERR;
                  end else if (tap_cur_q == tap_center_q) begin
                     state_d = ST_FIN_OK;
                  end else begin
                     phase_d = CP_MOVE;
                  end
               end
               default: begin
                  tap_cur_d = tap_cur_q - TAP_W'(1);
                  phase_d   = CP_GAP;
                  if (delay_line_out_of_range_i) begin
                     fail_code_d = FC_RANGE;
                     state_d     = ST_FIN_ERR;
                  end
               end
            endcase
         end
         ST_FIN_OK: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_FIN_ERR: begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge fab_clk_i) begin
      if (rx_sync_rst_i) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_ALIGN;
         phase_q      <= CP_ENTRY;
         slip_cnt_q   <= '0;
         settle_q     <= '0;
         oor_seen_q   <= 1'b0;
         dir_q        <= 1'b0;
         tap_cur_q    <= '0;
         win_start_q  <= '0;
         win_end_q    <= '0;
         tap_center_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_code_q  <= FC_NONE;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         phase_q      <= phase_d;
         slip_cnt_q   <= slip_cnt_d;
         settle_q     <= settle_d;
         oor_seen_q   <= oor_seen_d;
         dir_q        <= dir_d;
         tap_cur_q    <= tap_cur_d;
         win_start_q  <= win_start_d;
         win_end_q    <= win_end_d;
         tap_center_q <= tap_center_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         fail_code_q  <= fail_code_d;
      end
   end

   assign delay_line_load_o      = (state_q == ST_LOAD);
   assign rx_bit_slip_o          = (state_q == ST_SLIP);
   assign delay_line_move_o      = ((state_q == ST_STEP) && (tap_cur_q != TAP_LAST)) ||
                                   ((state_q == ST_CENTER) && (phase_q == CP_MOVE));
   assign delay_line_direction_o = dir_q;
   assign busy_o                 = busy_q;
   assign done_o                 = done_q;
   assign fail_o                 = fail_q;
   assign fail_code_o            = fail_code_q;
   assign tap_cur_o              = tap_cur_q;
   assign win_start_o            = win_start_q;
   assign win_end_o              = win_end_q;
   assign tap_center_o           = tap_center_q;

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Directed bench for ddr3_rx_lane_align with a behavioural IOD model that
// rotates the word per slip and passes the pattern only inside a tap window.
module tb_ddr3_rx_lane_align;

   logic       fab_clk = 1'b0;
   logic       rst_i, start_i, oor_i;
   logic [7:0] rx_data;
   logic       slip_o, load_o, move_o, dir_o, busy_o, done_o, fail_o;
   logic [1:0] fail_code_o;
   logic [7:0] tap_cur_o, win_start_o, win_end_o, tap_center_o;

   always #5 fab_clk = ~fab_clk;

   ddr3_rx_lane_align dut (
      .fab_clk_i                 (fab_clk),
      .rx_sync_rst_i             (rst_i),
      .start_i                   (start_i),
      .rx_data_i                 (rx_data),
      .delay_line_out_of_range_i (oor_i),
      .rx_bit_slip_o             (slip_o),
      .delay_line_load_o         (load_o),
      .delay_line_move_o         (move_o),
      .delay_line_direction_o    (dir_o),
      .busy_o                    (busy_o),
      .done_o                    (done_o),
      .fail_o                    (fail_o),
      .fail_code_o               (fail_code_o),
      .tap_cur_o                 (tap_cur_o),
      .win_start_o               (win_start_o),
      .win_end_o                 (win_end_o),
      .tap_center_o              (tap_center_o)
   );

   int total = 0;
   int bad   = 0;

   // IOD model configuration and observed pulse counts
   int m_need = 0, m_wlo = 0, m_whi = 0, m_oor = -1;
   int mtap = 0, ms = 0;
   int nslip = 0, ninc = 0, ndec = 0, nload = 0, inv_err = 0;
   bit oor_arm = 0;
   bit pmove = 0, pload = 0, pslip = 0, pdir = 0;
   bit first_load = 0;

   typedef struct {
      int need; int wlo; int whi; int oor_tap;
      int e_done; int e_fail; int e_code;
      int e_slips; int e_inc; int e_dec;
      int e_wend; int e_center; int e_tap;
   } scen_t;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [7:0] iod_word(input int s, input int t);
      logic [7:0] p;
      int         r;
      p = 8'hB4;
      if (m_need >= 8 || t < m_wlo || t > m_whi) return 8'h00;
      r = (m_need - s) & 7;
      if (r == 0) return p;
      return (p << r) | (p >> (8 - r));
   endfunction

   initial begin
      forever begin
         @(negedge fab_clk);
         oor_i   = oor_arm;
         oor_arm = 0;
         if (busy_o && int'(tap_cur_o) != mtap) inv_err++;
         if ((int'(load_o) + int'(move_o) + int'(slip_o)) > 1) inv_err++;
         if ((move_o && pmove) || (load_o && pload) || (slip_o && pslip)) inv_err++;
         if ((move_o || pmove) && (dir_o != pdir)) inv_err++;
         if (load_o) begin mtap = 0; nload++; end
         if (slip_o) begin ms++; nslip++; end
         if (move_o && dir_o) begin
            mtap++; ninc++;
            if (mtap == m_oor) oor_arm = 1;
         end else if (move_o) begin
            mtap--; ndec++;
         end
         rx_data = iod_word(ms, mtap);
         pmove = move_o; pload = load_o; pslip = slip_o; pdir = dir_o;
      end
   end

   task automatic setup(input int need, input int wlo, input int whi, input int oor_tap);
      m_need = need; m_wlo = wlo; m_whi = whi; m_oor = oor_tap;
      mtap = 0; ms = 0; nslip = 0; ninc = 0; ndec = 0; nload = 0; inv_err = 0;
   endtask

   task automatic run_scen(input int need, input int wlo, input int whi,
                           input int oor_tap, input int restart_at);
      int cyc;
      setup(need, wlo, whi, oor_tap);
      start_i = 1'b1;
      @(negedge fab_clk);
      start_i    = 1'b0;
      first_load = load_o;
      cyc = 0;
      while (busy_o && cyc < 6000) begin
         start_i = (cyc == restart_at);
         @(negedge fab_clk);
         cyc++;
      end
      start_i = 1'b0;
      if (busy_o) check("timeout_busy", 1, 0);
   endtask

   task automatic check_result(input string tag, input scen_t s);
      check({tag, "_done"},      int'(done_o),       s.e_done);
      check({tag, "_fail"},      int'(fail_o),       s.e_fail);
      check({tag, "_code"},      int'(fail_code_o),  s.e_code);
      check({tag, "_slips"},     nslip,              s.e_slips);
      check({tag, "_inc"},       ninc,               s.e_inc);
      check({tag, "_dec"},       ndec,               s.e_dec);
      check({tag, "_loads"},     nload,              1);
      check({tag, "_win_start"}, int'(win_start_o),  0);
      check({tag, "_win_end"},   int'(win_end_o),    s.e_wend);
      check({tag, "_center"},    int'(tap_center_o), s.e_center);
      check({tag, "_tap_cur"},   int'(tap_cur_o),    s.e_tap);
      check({tag, "_invariants"}, inv_err,           0);
   endtask

   scen_t tbl[5];
   scen_t s_busy, s_fresh;

   initial begin
      int snap, cyc;
      tbl[0] = '{8, 0,  40, -1, 0, 1, 1, 7,   0,  0,   0,  0,  0};
      tbl[1] = '{0, 0,   2, -1, 0, 1, 2, 0,   3,  0,   2,  0,  3};
      tbl[2] = '{3, 0,  40, -1, 1, 0, 0, 3,  41, 21,  40, 20, 20};
      tbl[3] = '{1, 0, 127, -1, 1, 0, 0, 1, 127, 64, 127, 63, 63};
      tbl[4] = '{2, 0, 127, 50, 1, 0, 0, 2,  50, 26,  49, 24, 24};
      s_busy  = '{3, 0, 40, -1, 1, 0, 0, 3, 41, 21, 40, 20, 20};
      s_fresh = '{1, 0, 40, -1, 1, 0, 0, 1, 41, 21, 40, 20, 20};

      rst_i = 1'b1; start_i = 1'b0; oor_i = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge fab_clk);
      check("reset_outputs", int'({busy_o, done_o, fail_o, fail_code_o, tap_cur_o, win_start_o,
                                   win_end_o, tap_center_o, load_o, move_o, slip_o, dir_o}), 0);
      rst_i = 1'b0;
      @(negedge fab_clk);

      for (int i = 0; i < 5; i++) begin
         run_scen(tbl[i].need, tbl[i].wlo, tbl[i].whi, tbl[i].oor_tap, -1);
         check_result($sformatf("scen%0d", i), tbl[i]);
         repeat (3) @(negedge fab_clk);
      end

      // START pulsed mid-training must not disturb the sequence
      run_scen(3, 0, 40, -1, 100);
      check_result("start_busy", s_busy);
      repeat (3) @(negedge fab_clk);

      // Reset at tap 30 aborts training
      setup(0, 0, 127, -1);
      start_i = 1'b1;
      @(negedge fab_clk);
      start_i = 1'b0;
      cyc = 0;
      while (int'(tap_cur_o) != 30 && cyc < 3000) begin
         @(negedge fab_clk);
         cyc++;
      end
      check("reach_tap30", int'(tap_cur_o), 30);
      rst_i = 1'b1;
      @(negedge fab_clk);
      rst_i = 1'b0;
      check("mid_reset_outputs", int'({busy_o, done_o, fail_o, fail_code_o, tap_cur_o, win_start_o,
                                       win_end_o, tap_center_o, load_o, move_o, slip_o, dir_o}), 0);
      mtap = 0;
      snap = nslip + ninc + ndec + nload;
      repeat (40) @(negedge fab_clk);
      check("post_reset_pulses", nslip + ninc + ndec + nload - snap, 0);
      check("post_reset_busy", int'(busy_o), 0);

      // Fresh START after reset: LOAD pulse first, then normal completion
      run_scen(1, 0, 40, -1, -1);
      check("fresh_first_load", int'(first_load), 1);
      check_result("fresh", s_fresh);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
